// File: rtl/spm_loader_pkg.sv
// Shared types and constants for the serial program loader.
// Build option: SPM_LOADER_CKSUM_EN adds a trailing checksum byte to each frame.
package spm_loader_pkg;

    // Protocol FSM states of the loader.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        ADDR  = 3'd2,
        DATA  = 3'd3,
`ifdef SPM_LOADER_CKSUM_EN
        CKSUM = 3'd4,
`endif
        DONE  = 3'd5
    } loader_state_t;

    // UART receiver states.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h5A;

    // Half a bit period: distance from the start-bit edge to its midpoint.
    function automatic int unsigned half_bit(input int unsigned clks_per_bit);
        return clks_per_bit / 32'd2;
    endfunction

endpackage

// File: rtl/spm_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, LSB first.
// Emits one-cycle byte_valid on a good stop bit, one-cycle frame_err on a bad one.
// Only a falling edge on the synchronized line starts a byte, so a line left
// low after a framing error does not trigger spurious receptions.
module spm_uart_rx
    import spm_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam logic [15:0] HALF_LAST = 16'(half_bit(CLKS_PER_BIT) - 32'd1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 32'd1);

    logic       rx_meta_r;
    logic       rx_sync_r;
    logic       rx_last_r;
    rx_state_t  state_r;
    logic [15:0] baud_cnt_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic [7:0] byte_r;
    logic       valid_r;
    logic       ferr_r;

    // Synchronize the asynchronous line and keep one sample of history for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_last_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_last_r <= rx_sync_r;
        end
    end

    // Bit timing, shifting and stop-bit check.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= RX_IDLE;
            baud_cnt_r <= 16'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            byte_r     <= 8'h00;
            valid_r    <= 1'b0;
            ferr_r     <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            case (state_r)
                RX_IDLE: begin
                    baud_cnt_r <= 16'd0;
                    bit_cnt_r  <= 3'd0;
                    if (rx_last_r && !rx_sync_r) begin
                        state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (baud_cnt_r == HALF_LAST) begin
                        baud_cnt_r <= 16'd0;
                        state_r    <= rx_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (baud_cnt_r == BIT_LAST) begin
                        baud_cnt_r <= 16'd0;
                        shift_r    <= {rx_sync_r, shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= RX_STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (baud_cnt_r == BIT_LAST) begin
                        baud_cnt_r <= 16'd0;
                        state_r    <= RX_IDLE;
                        if (rx_sync_r) begin
                            valid_r <= 1'b1;
                            byte_r  <= shift_r;
                        end else begin
                            ferr_r <= 1'b1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= RX_IDLE;
                end
            endcase
        end
    end

    assign rx_byte    = byte_r;
    assign byte_valid = valid_r;
    assign frame_err  = ferr_r;

endmodule

// File: rtl/spm_prog_loader.sv
// Serial program loader for the RISC_SPM core.
// Frame: SYNC, LEN (0 means 256), ADDR, data bytes, optional checksum.
// Build option: SPM_LOADER_CKSUM_EN enables the trailing 8-bit sum checksum.
// A frame that fails keeps cpu_rst asserted so a partial image never runs.
module spm_prog_loader
    import spm_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       ext_write,
    output logic [7:0] address_bus,
    output logic [7:0] data_bus,
    output logic       cpu_rst,
    output logic       busy,
    output logic       err
);

    logic [7:0]    rx_byte_s;
    logic          rx_valid_s;
    logic          rx_ferr_s;

    loader_state_t state_r;
    logic [8:0]    remaining_r;
    logic [7:0]    addr_cnt_r;
    logic          ext_write_r;
    logic [7:0]    address_bus_r;
    logic [7:0]    data_bus_r;
    logic          cpu_rst_r;
    logic          busy_r;
    logic          err_r;
`ifdef SPM_LOADER_CKSUM_EN
    logic [7:0]    sum_r;
`endif

    spm_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_byte    (rx_byte_s),
        .byte_valid (rx_valid_s),
        .frame_err  (rx_ferr_s)
    );

    // Frame decoding, memory write generation and core reset control.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            remaining_r   <= 9'd0;
            addr_cnt_r    <= 8'h00;
            ext_write_r   <= 1'b0;
            address_bus_r <= 8'h00;
            data_bus_r    <= 8'h00;
            cpu_rst_r     <= 1'b0;
            busy_r        <= 1'b0;
            err_r         <= 1'b0;
`ifdef SPM_LOADER_CKSUM_EN
            sum_r         <= 8'h00;
`endif
        end else begin
            ext_write_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (rx_ferr_s) begin
                        err_r <= 1'b1;
                    end else if (rx_valid_s && (rx_byte_s == SYNC_BYTE)) begin
                        cpu_rst_r <= 1'b1;
                        busy_r    <= 1'b1;
                        err_r     <= 1'b0;
`ifdef SPM_LOADER_CKSUM_EN
                        sum_r     <= 8'h00;
`endif
                        state_r   <= LEN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LEN: begin
                    if (rx_ferr_s) begin
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (rx_valid_s) begin
                        remaining_r <= (rx_byte_s == 8'h00) ? 9'd256 : {1'b0, rx_byte_s};
                        state_r     <= ADDR;
                    end else begin
                        state_r <= LEN;
                    end
                end
                ADDR: begin
                    if (rx_ferr_s) begin
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (rx_valid_s) begin
                        addr_cnt_r <= rx_byte_s;
                        state_r    <= DATA;
                    end else begin
                        state_r <= ADDR;
                    end
                end
                DATA: begin
                    // Leave only after the final strobe cycle, so DONE follows it.
                    if (remaining_r == 9'd0) begin
`ifdef SPM_LOADER_CKSUM_EN
                        state_r <= CKSUM;
`else
                        state_r <= DONE;
`endif
                    end else if (rx_ferr_s) begin
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (rx_valid_s) begin
                        ext_write_r   <= 1'b1;
                        address_bus_r <= addr_cnt_r;
                        data_bus_r    <= rx_byte_s;
                        addr_cnt_r    <= addr_cnt_r + 8'd1;
                        remaining_r   <= remaining_r - 9'd1;
`ifdef SPM_LOADER_CKSUM_EN
                        sum_r         <= sum_r + rx_byte_s;
`endif
                    end else begin
                        state_r <= DATA;
                    end
                end
`ifdef SPM_LOADER_CKSUM_EN
                CKSUM: begin
                    if (rx_ferr_s) begin
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (rx_valid_s) begin
                        if (rx_byte_s == sum_r) begin
                            state_r <= DONE;
                        end else begin
                            err_r   <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= CKSUM;
                    end
                end
`endif
                DONE: begin
                    cpu_rst_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ext_write   = ext_write_r;
    assign address_bus = address_bus_r;
    assign data_bus    = data_bus_r;
    assign cpu_rst     = cpu_rst_r;
    assign busy        = busy_r;
    assign err         = err_r;

endmodule

// File: tb/tb_spm_prog_loader.sv
// Self-checking bench for spm_prog_loader: drives UART frames on rx and
// compares captured memory writes and status flags against a frame-level model.
module tb_spm_prog_loader;

    localparam int unsigned CLKS = 8;
    localparam logic [7:0]  SYNC = 8'h5A;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       ext_write;
    logic [7:0] address_bus;
    logic [7:0] data_bus;
    logic       cpu_rst;
    logic       busy;
    logic       err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] wr_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  frame_d[$];
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          fall_cyc = 0;
    int          pulse_err = 0;
    logic        ext_write_q = 1'b0;
    logic        cpu_rst_q = 1'b0;
    logic [1:0]  mid_status;
    logic [2:0]  exp_status;   // {err, busy, cpu_rst}
`ifdef SPM_LOADER_CKSUM_EN
    bit          force_bad_sum = 1'b0;
`endif

    spm_prog_loader #(
        .CLKS_PER_BIT (CLKS),
        .SYNC_BYTE    (SYNC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .ext_write   (ext_write),
        .address_bus (address_bus),
        .data_bus    (data_bus),
        .cpu_rst     (cpu_rst),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: capture strobes, detect stretched pulses, time cpu_rst release.
    always @(negedge clk) begin
        if (ext_write === 1'b1) begin
            wr_q.push_back({address_bus, data_bus});
            last_wr_cyc <= cyc;
        end
        if (ext_write === 1'b1 && ext_write_q === 1'b1) pulse_err <= pulse_err + 1;
        if (cpu_rst_q === 1'b1 && cpu_rst === 1'b0) fall_cyc <= cyc;
        ext_write_q <= ext_write;
        cpu_rst_q   <= cpu_rst;
    end

    function automatic int wr_diff();
        int d;
        d = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) d++;
        if (wr_q.size() > exp_q.size()) d += wr_q.size() - exp_q.size();
        return d;
    endfunction

    function automatic logic [7:0] noise_byte();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h00;
        return b;
    endfunction

    task automatic start_test();
        wr_q.delete();
        exp_q.delete();
        frame_d.delete();
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CLKS) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLKS) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CLKS) @(negedge clk);
        rx = 1'b1;
        if (!stop_ok) repeat (2 * CLKS) @(negedge clk);
    endtask

    // Sends one frame from frame_d; the expected writes are simply data[i] at addr+i mod 256.
    task automatic send_frame(input int len_field, input logic [7:0] addr, input int bad_at);
        int n;
        logic [7:0] sum;
        logic [7:0] a;
        n   = (len_field == 0) ? 256 : len_field;
        sum = 8'h00;
        a   = addr;
        send_byte(SYNC, 1'b1);
        send_byte(8'(len_field), 1'b1);
        send_byte(addr, 1'b1);
        mid_status = {busy, cpu_rst};
        for (int i = 0; i < n; i++) begin
            if (i == bad_at) begin
                send_byte(frame_d[i], 1'b0);
                exp_status = 3'b101;
                idle_bits(2);
                return;
            end
            send_byte(frame_d[i], 1'b1);
            exp_q.push_back({a, frame_d[i]});
            a   = a + 8'd1;
            sum = sum + frame_d[i];
        end
`ifdef SPM_LOADER_CKSUM_EN
        send_byte(force_bad_sum ? (sum ^ 8'h02) : sum, 1'b1);
        exp_status = force_bad_sum ? 3'b101 : 3'b000;
`else
        exp_status = 3'b000;
`endif
        idle_bits(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            rx = ~rx;
            @(negedge clk);
        end
        tests_run++; if (ext_write !== 1'b0) begin tests_failed++; $display("FAIL reset_ext_write: got %b want 0", ext_write); end
        tests_run++; if (address_bus !== 8'h00) begin tests_failed++; $display("FAIL reset_address: got %h want 00", address_bus); end
        tests_run++; if (data_bus !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h want 00", data_bus); end
        tests_run++; if ({err, busy, cpu_rst} !== 3'b000) begin tests_failed++; $display("FAIL reset_status: got %b want 000", {err, busy, cpu_rst}); end
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle_bits(4);
        tests_run++; if (wr_q.size() !== 0) begin tests_failed++; $display("FAIL reset_no_write: got %0d writes want 0", wr_q.size()); end
        tests_run++; if ({err, busy, cpu_rst} !== 3'b000) begin tests_failed++; $display("FAIL reset_idle_status: got %b want 000", {err, busy, cpu_rst}); end
    endtask

    task automatic test_basic();
        start_test();
        frame_d = '{8'h11, 8'h22, 8'h33};
        send_frame(3, 8'h10, -1);
        tests_run++; if (mid_status !== 2'b11) begin tests_failed++; $display("FAIL basic_mid_busy_cpu_rst: got %b want 11", mid_status); end
        tests_run++; if (wr_diff() !== 0) begin tests_failed++; $display("FAIL basic_writes: got %0d writes, %0d wrong, want %0d", wr_q.size(), wr_diff(), exp_q.size()); end
        tests_run++; if (wr_q.size() != 3 || wr_q[2] !== 16'h1233) begin tests_failed++; $display("FAIL basic_last_write: got %0d writes, want last 1233", wr_q.size()); end
        tests_run++; if ({err, busy, cpu_rst} !== exp_status) begin tests_failed++; $display("FAIL basic_status: got %b want %b", {err, busy, cpu_rst}, exp_status); end
`ifndef SPM_LOADER_CKSUM_EN
        tests_run++; if (fall_cyc - last_wr_cyc !== 2) begin tests_failed++; $display("FAIL basic_release_timing: got %0d cycles want 2", fall_cyc - last_wr_cyc); end
`endif
    endtask

    task automatic test_wrap();
        start_test();
        frame_d = '{8'hAA, 8'hBB};
        send_frame(2, 8'hFF, -1);
        tests_run++; if (wr_diff() !== 0) begin tests_failed++; $display("FAIL wrap_writes: got %0d writes, %0d wrong, want %0d", wr_q.size(), wr_diff(), exp_q.size()); end
        tests_run++; if (wr_q.size() != 2 || wr_q[1] !== 16'h00BB) begin tests_failed++; $display("FAIL wrap_second_addr: got %0d writes, want second 00BB", wr_q.size()); end
        tests_run++; if ({err, busy, cpu_rst} !== exp_status) begin tests_failed++; $display("FAIL wrap_status: got %b want %b", {err, busy, cpu_rst}, exp_status); end
    endtask

    task automatic test_len_zero();
        start_test();
        for (int i = 0; i < 256; i++) frame_d.push_back(8'($urandom_range(0, 255)));
        send_frame(0, 8'h00, -1);
        tests_run++; if (wr_q.size() !== 256) begin tests_failed++; $display("FAIL len0_count: got %0d writes want 256", wr_q.size()); end
        tests_run++; if (wr_diff() !== 0) begin tests_failed++; $display("FAIL len0_writes: %0d wrong of %0d", wr_diff(), exp_q.size()); end
        tests_run++; if ({err, busy, cpu_rst} !== exp_status) begin tests_failed++; $display("FAIL len0_status: got %b want %b", {err, busy, cpu_rst}, exp_status); end
    endtask

    task automatic test_idle_noise();
        start_test();
        send_byte(8'h00, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'hFF, 1'b1);
        tests_run++; if ({err, busy, cpu_rst, wr_q.size() == 0} !== 4'b0001) begin tests_failed++; $display("FAIL noise_ignored: got status %b, %0d writes, want 000 and 0", {err, busy, cpu_rst}, wr_q.size()); end
        frame_d = '{8'h77};
        send_frame(1, 8'h20, -1);
        tests_run++; if (wr_diff() !== 0) begin tests_failed++; $display("FAIL noise_writes: got %0d writes, %0d wrong, want %0d", wr_q.size(), wr_diff(), exp_q.size()); end
        tests_run++; if ({err, busy, cpu_rst} !== exp_status) begin tests_failed++; $display("FAIL noise_status: got %b want %b", {err, busy, cpu_rst}, exp_status); end
    endtask

    task automatic test_idle_framing_err();
        start_test();
        send_byte(noise_byte(), 1'b0);
        idle_bits(2);
        tests_run++; if ({err, busy, cpu_rst} !== 3'b100) begin tests_failed++; $display("FAIL idle_ferr_status: got %b want 100", {err, busy, cpu_rst}); end
        tests_run++; if (wr_q.size() !== 0) begin tests_failed++; $display("FAIL idle_ferr_writes: got %0d want 0", wr_q.size()); end
    endtask

    task automatic test_framing_err();
        start_test();
        frame_d = '{8'h11, 8'h22, 8'h33};
        send_frame(3, 8'h40, 1);
        tests_run++; if ({err, busy, cpu_rst} !== exp_status) begin tests_failed++; $display("FAIL ferr_status: got %b want %b", {err, busy, cpu_rst}, exp_status); end
        tests_run++; if (wr_diff() !== 0 || wr_q.size() !== 1) begin tests_failed++; $display("FAIL ferr_writes: got %0d writes, %0d wrong, want 1 (4011)", wr_q.size(), wr_diff()); end
        start_test();
        for (int i = 0; i < 4; i++) frame_d.push_back(8'($urandom_range(0, 255)));
        send_frame(4, 8'($urandom_range(0, 255)), -1);
        tests_run++; if ({err, busy, cpu_rst} !== exp_status) begin tests_failed++; $display("FAIL ferr_recover_status: got %b want %b", {err, busy, cpu_rst}, exp_status); end
        tests_run++; if (wr_diff() !== 0) begin tests_failed++; $display("FAIL ferr_recover_writes: got %0d writes, %0d wrong, want %0d", wr_q.size(), wr_diff(), exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int len;
        start_test();
        for (int f = 0; f < 5; f++) begin
            int nn;
            nn = $urandom_range(0, 2);
            for (int k = 0; k < nn; k++) send_byte(noise_byte(), 1'b1);
            len = $urandom_range(2, 10);
            frame_d.delete();
            for (int i = 0; i < len; i++) frame_d.push_back(8'($urandom_range(0, 255)));
            frame_d[1] = SYNC;   // a sync value inside data must be stored, not resync
            send_frame(len, 8'($urandom_range(0, 255)), -1);
            tests_run++; if ({err, busy, cpu_rst} !== exp_status) begin tests_failed++; $display("FAIL b2b_status_%0d: got %b want %b", f, {err, busy, cpu_rst}, exp_status); end
        end
        tests_run++; if (wr_diff() !== 0) begin tests_failed++; $display("FAIL b2b_writes: got %0d writes, %0d wrong, want %0d", wr_q.size(), wr_diff(), exp_q.size()); end
        tests_run++; if (pulse_err !== 0) begin tests_failed++; $display("FAIL strobe_width: got %0d stretched strobes want 0", pulse_err); end
    endtask

`ifdef SPM_LOADER_CKSUM_EN
    task automatic test_cksum();
        start_test();
        frame_d = '{8'h01, 8'h02, 8'h03};
        force_bad_sum = 1'b0;
        send_frame(2, 8'h00, -1);
        tests_run++; if ({err, busy, cpu_rst} !== 3'b000) begin tests_failed++; $display("FAIL cksum_good_status: got %b want 000", {err, busy, cpu_rst}); end
        start_test();
        frame_d = '{8'h01, 8'h02, 8'h03};
        force_bad_sum = 1'b1;
        send_frame(3, 8'h00, -1);
        force_bad_sum = 1'b0;
        tests_run++; if ({err, busy, cpu_rst} !== 3'b101) begin tests_failed++; $display("FAIL cksum_bad_status: got %b want 101", {err, busy, cpu_rst}); end
        tests_run++; if (wr_diff() !== 0) begin tests_failed++; $display("FAIL cksum_bad_writes: got %0d writes, %0d wrong, want %0d", wr_q.size(), wr_diff(), exp_q.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_len_zero();
        test_idle_noise();
        test_idle_framing_err();
        test_framing_err();
        test_back_to_back();
`ifdef SPM_LOADER_CKSUM_EN
        test_cksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spm_prog_loader.md
# spm_prog_loader

Serial program loader that sits directly upstream of the RISC_SPM core. It receives an 8N1 UART byte stream on one user I/O pin and decodes a small framed protocol. It drives the core's external-write port (ext_write, address_bus, data_bus) to fill the core's memory, and holds the core in reset for the duration of the load.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: clk cycles per UART bit; legal range 4..65535.
- SYNC_BYTE, default 8'h5A: frame start marker.

Ports:
- clk  input  1  system clock (wb_clk_i at the top level).
- rst_n  input  1  synchronous, active-low reset.
- rx  input  1  UART serial input, asynchronous, idle high.
- ext_write  output  1  one-cycle write strobe to the core.
- address_bus  output  8  write address; held stable between strobes.
- data_bus  output  8  write data; held stable between strobes.
- cpu_rst  output  1  active-high reset request to the core; high while a frame is in progress.
- busy  output  1  high from sync byte accepted until frame end or abort.
- err  output  1  sticky error flag; cleared by reset or by the next accepted sync byte.

## Operation
- rx passes through a 2-flop synchronizer; all decoding uses the synchronized copy.
- UART RX:
  - A start bit is qualified by rx still low at CLKS_PER_BIT/2.
  - Data bits are sampled at mid-bit, LSB first.
  - The stop bit must be 1.
  - A stop bit of 0 is a framing error: the byte is dropped and err is set.
- Frame format: SYNC_BYTE, LEN, ADDR, then D[0..N-1], then (optional) CKSUM.
  - N = LEN, and LEN=0 means N=256.
- FSM states: IDLE, LEN, ADDR, DATA, CKSUM, DONE.
  - IDLE: any byte other than SYNC_BYTE is ignored. SYNC_BYTE sets cpu_rst=1 and busy=1, clears err, and moves to LEN.
  - LEN: stores the count and moves to ADDR.
  - ADDR: loads the address counter and moves to DATA.
  - DATA: each byte drives data_bus=byte and address_bus=counter, then pulses ext_write. The counter increments mod 256 (0xFF wraps to 0x00). After N bytes, go to CKSUM if enabled, otherwise DONE.
  - DONE: lasts one cycle; drops cpu_rst and busy, then returns to IDLE.
- Framing error in any state other than IDLE:
  - Set err, drop busy and go to IDLE.
  - cpu_rst stays 1; a corrupted image is never released.
  - cpu_rst clears only on a later successful DONE or on reset.
- A framing error in IDLE sets err only.
- SYNC_BYTE received mid-frame is treated as ordinary data; the loader does not resync.

## Timing
- Reset values: ext_write=0, address_bus=8'h00, data_bus=8'h00, cpu_rst=0, busy=0, err=0. The FSM is in IDLE and the RX is idle.
- Byte-valid latency: byte-valid asserts 2 (synchronizer) + 9.5·CLKS_PER_BIT cycles after the falling edge of the start bit on rx.
- ext_write is high for exactly one cycle, in the cycle after byte-valid.
  - address_bus and data_bus are valid in that same cycle and hold until the next strobe.
- cpu_rst:
  - Rises the cycle after the sync byte is valid.
  - Falls the cycle after the DONE state, i.e. 2 cycles after the final ext_write (no checksum), or 2 cycles after the checksum byte-valid.
- The RX accepts back-to-back bytes with no inter-byte gap.

## Configuration
- SPM_LOADER_CKSUM_EN defined:
  - A CKSUM byte follows the data.
  - Checksum = 8-bit sum mod 256 of all data bytes.
  - Match: go to DONE.
  - Mismatch: set err, drop busy, go to IDLE with cpu_rst held at 1.
- SPM_LOADER_CKSUM_EN undefined:
  - The CKSUM state and checksum accumulator are absent.
  - DATA goes straight to DONE.

## Structure
- Package spm_loader_pkg holds:
  - the FSM state enum;
  - the SYNC_BYTE default;
  - the helper constant HALF_BIT = CLKS_PER_BIT/2 (as a function).
- One sub-module, spm_uart_rx:
  - contains the synchronizer, bit counter, baud counter and shift register;
  - outputs byte[7:0], byte_valid (one-cycle pulse) and frame_err (one-cycle pulse).
- The top-level loader holds the protocol FSM, the address/length counters and the checksum.

## Test plan
- Reset: hold rst_n=0 for 3 cycles -> all outputs 0; rx toggling during reset produces no ext_write.
- Basic load: send 5A 03 10 11 22 33 -> three ext_write pulses, (0x10,0x11), (0x11,0x22), (0x12,0x33). cpu_rst is high from the sync byte until 2 cycles after the last pulse.
- Wrap and LEN=0:
  - Send 5A 02 FF AA BB -> writes at 0xFF then 0x00.
  - Send 5A 00 00 plus 256 bytes -> 256 strobes covering 0x00..0xFF.
- Idle noise: send 00 A5 FF before 5A 01 20 77 -> exactly one write, (0x20,0x77); err stays 0.
- Framing error: drive the stop bit low on the second data byte of 5A 03 40 ... -> err=1, busy=0, cpu_rst=1, a single write at 0x40. A following good frame clears err and releases cpu_rst.
- Checksum (SPM_LOADER_CKSUM_EN):
  - Send 5A 02 00 01 02 03 -> cpu_rst released, err=0.
  - Same frame with CKSUM 04 -> err=1, cpu_rst held at 1.
